pipe_stage_reg: RTL and testbench

Parametrised, flow-controlled pipeline stage register that replaces the fixed load-enabled inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a `WIDTH`-bit payload (packed control word + operands) under a valid/ready handshake, and supports flush-to-bubble for branch/jump squashing. An optional skid buffer registers the upstream ready path to break long stall chains.

---
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic flow-controlled pipeline stage register. It replaces the fixed,
// load-enabled inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with a
// single block that carries a WIDTH-bit payload under a valid/ready
// handshake. It can also squash every held entry to a bubble for branch and
// jump recovery.
//
// Optional feature (compile-time macro PIPE_STAGE_SKID_EN):
//   Undefined : a single main register. in_ready = !m_valid | out_ready, which
//               is combinational from out_ready.
//   Defined   : adds a skid register, so the stage holds two entries and
//               in_ready comes straight from a flop. This breaks long
//               upstream stall chains.
//
// Parameters:
//   WIDTH     payload width in bits
//   NOP_DATA  bubble encoding shown on out_data after rst/flush
//
// Ports:
//   clk        in   stage clock; all state updates on posedge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous squash of all held entries
//   in_valid   in   upstream payload valid
//   in_ready   out  stage can accept this cycle
//   in_data    in   upstream payload
//   out_valid  out  out_data holds a live entry (registered)
//   out_ready  in   downstream accepts this cycle
//   out_data   out  head payload (registered)
//   occupancy  out  live entries held (0..2)
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned        WIDTH    = 32,
  parameter logic [WIDTH-1:0]   NOP_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Main register: this register alone drives the outputs.
  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q,  m_data_d;

  logic in_fire;
  logic out_fire;

  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = m_valid_q & out_ready;

`ifdef PIPE_STAGE_SKID_EN

  // Skid register: catches the word accepted while main is stalled.
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q,  s_data_d;

  // Registered ready: the stage refuses input only when both slots are full.
  assign in_ready  = ~s_valid_q;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  // NOTE: give every comb output a default before any branch. A path that
  // leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;

    if (!m_valid_q || out_fire) begin
      // Main is free this cycle. Refill it from skid first so that the
      // stage keeps strict FIFO order.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = in_fire;
        if (in_fire) begin
          s_data_d = in_data;
        end
      end else if (in_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else begin
        // Drained: m_data is kept as it is, because out_data is don't-care
        // while out_valid is low.
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // Main is stalled and holds its data. Park the new word in skid.
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
  end

  // NOTE: the data registers are reset as well as the valid bits, because
  // out_data must show exactly NOP_DATA after rst/flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s_valid_q <= 1'b0;
      s_data_q  <= NOP_DATA;
    end else begin
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

`else

  // Single-entry stage. A full register can still accept a word when the
  // downstream consumer drains it in the same cycle.
  assign in_ready  = ~m_valid_q | out_ready;
  assign occupancy = {1'b0, m_valid_q};

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (in_fire) begin
      m_valid_d = 1'b1;
      m_data_d  = in_data;
    end else if (out_fire) begin
      m_valid_d = 1'b0;
    end
  end

`endif

  // Reset takes priority over flush, and both have the same effect. Any
  // in_fire in that cycle is dropped.
  // NOTE: use non-blocking assignments for state. Every flop then samples
  // pre-edge values no matter in which order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid_q <= 1'b0;
      m_data_q  <= NOP_DATA;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. The reference model is a bounded
// FIFO queue:
//   - its capacity is 2 with the skid register and 1 without it;
//   - its head gives the expected out_data;
//   - its size gives the expected occupancy and out_valid;
//   - the acceptance rule gives the expected in_ready.
// Directed sequences cover reset, streaming, backpressure, flush and
// simultaneous in/out traffic. A long randomised run follows.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          WIDTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  pipe_stage_reg #(.WIDTH(WIDTH), .NOP_DATA(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state.
  logic [31:0] q[$];
  bit          known    = 1'b0;  // becomes 1 once a reset has defined the state
  bit          nop_flag = 1'b0;  // out_data must equal NOP while the queue is empty

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle. Inputs are driven 1 time unit after posedge and the
  // outputs are checked 1 unit later. The model then advances using the fires
  // that the model itself predicts.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] d, input logic ordy);
    bit exp_ir;
    bit in_fire;
    bit out_fire;
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    exp_ir = 1'b0;
    if (known) begin
      if (SKID) exp_ir = (q.size() < 2);
      else      exp_ir = (q.size() == 0) || ordy;
      check("in_ready",  {31'b0, in_ready},  {31'b0, exp_ir});
      check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
      check("occupancy", {30'b0, occupancy}, q.size());
      if (q.size() != 0) check("out_data", out_data, q[0]);
      else if (nop_flag) check("out_data_nop", out_data, NOP);
    end
    in_fire  = iv && exp_ir;
    out_fire = ordy && (q.size() != 0);
    @(posedge clk);
    #1;
    if (r || f) begin
      q.delete();
      nop_flag = 1'b1;
      known    = 1'b1;
    end else if (known) begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) begin
        q.push_back(d);
        nop_flag = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset: hold rst for 2 cycles while offering a word that must be ignored.
    step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);

    // Streaming: send 0x1..0x10 back-to-back, then drain.
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b0, 1'b1, i, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Backpressure: offer A, B, C with downstream stalled, then release.
    step(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Flush while full, with 0x55 offered in the same cycle.
    step(1'b0, 1'b0, 1'b1, 32'h21, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h55, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Simultaneous in_fire and out_fire at occupancy 1.
    step(1'b0, 1'b0, 1'b1, 32'h6, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h7, 1'b1);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    // Random valid/ready traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      logic r, f, iv, ordy;
      r    = ($urandom_range(0, 999) == 0);
      f    = ($urandom_range(0, 63) == 0);
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      step(r, f, iv, $urandom, ordy);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
